// File: rtl/pulse_gen_pkg.sv
// Shared constants, generator state encoding and the bpm clamp helper
// for the synthetic heart-pulse generator.
package pulse_gen_pkg;

  localparam int BPM_MIN       = 30;
  localparam int BPM_MAX       = 240;
  localparam int BPM_DEFAULT   = 60;
  localparam int TICKS_PER_MIN = 6000;

  localparam logic [7:0]  PERIOD_DEFAULT = 8'(TICKS_PER_MIN / BPM_DEFAULT);
  localparam logic [12:0] DIVIDEND       = 13'(TICKS_PER_MIN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } gen_state_e;

  function automatic logic [7:0] clamp_bpm(input logic [7:0] bpm);
    if (bpm < 8'(BPM_MIN)) return 8'(BPM_MIN);
    if (bpm > 8'(BPM_MAX)) return 8'(BPM_MAX);
    return bpm;
  endfunction

endpackage

// File: rtl/div_ticks.sv
// Restoring divider: 6000 / divisor over exactly 13 cycles. The divisor must
// stay stable while busy; start at any time restarts from scratch.
module div_ticks
  import pulse_gen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [7:0] quotient
);

  logic [12:0] dvd;
  logic [7:0]  rem;
  logic [3:0]  step;
  logic [8:0]  rem_sh;
  logic        fits;
  logic [7:0]  rem_nxt;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no path infers a latch.
    rem_sh  = {rem, dvd[12]};
    fits    = rem_sh >= {1'b0, divisor};
    rem_nxt = rem_sh[7:0];
    if (fits) rem_nxt = 8'(rem_sh - {1'b0, divisor});
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      quotient <= '0;
      dvd      <= '0;
      rem      <= '0;
      step     <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        step <= '0;
        dvd  <= DIVIDEND;
        rem  <= '0;
      end else if (busy) begin
        rem  <= rem_nxt;
        dvd  <= {dvd[11:0], fits};
        step <= step + 4'd1;
        if (step == 4'd12) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          quotient <= {dvd[6:0], fits};
        end
      end
    end
  end

endmodule

// File: rtl/pulse_gen.sv
// Synthetic sensor pulse generator: tick prescaler, beat FSM and a deferred
// period update so a running beat never changes length.
module pulse_gen
  import pulse_gen_pkg::*;
#(
  parameter int TICK_DIV   = 1000000,
  parameter int HIGH_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       load,
  input  logic [7:0] bpm_set,
  output logic       pulse_out,
  output logic       beat,
  output logic [7:0] period,
  output logic       busy
);

  localparam int         PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0] HIGH_LAST = 8'(HIGH_TICKS - 1);

  logic [1:0]    rst_sync;
  logic          rst_n;
  logic [PW-1:0] presc;
  logic          tick;
  logic [7:0]    bpm_q;
  logic          done;
  logic [7:0]    quotient;
  gen_state_e    state;
  logic [7:0]    tcnt;
  logic [7:0]    low_last;
  logic [7:0]    pend;
  logic          pend_valid;
  logic          eff_valid;
  logic [7:0]    eff_val;
  logic          boundary;
  logic          apply;

  // Async assert, sync release of the internal reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rst_sync <= 2'b00;
    else      rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          presc <= '0;
    else if (presc == PW'(TICK_DIV - 1)) presc <= '0;
    else                                 presc <= presc + 1'b1;
  end
  assign tick = (presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    bpm_q <= 8'(BPM_DEFAULT);
    else if (load) bpm_q <= clamp_bpm(bpm_set);
  end

  div_ticks u_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (load),
    .divisor  (bpm_q),
    .busy     (busy),
    .done     (done),
    .quotient (quotient)
  );

  // A result finishing this cycle counts as pending already.
  assign eff_valid = done | pend_valid;
  assign eff_val   = done ? quotient : pend;
  assign low_last  = period - 8'(HIGH_TICKS + 1);
  assign boundary  = enb && (state == ST_LOW) && tick && (tcnt == low_last);
  assign apply     = eff_valid && ((state == ST_IDLE) || boundary);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period     <= PERIOD_DEFAULT;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else if (apply) begin
      period     <= eff_val;
      pend_valid <= 1'b0;
    end else if (done) begin
      pend       <= quotient;
      pend_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      tcnt  <= '0;
      beat  <= 1'b0;
    end else begin
      beat <= 1'b0;
      if (!enb) begin
        state <= ST_IDLE;
        tcnt  <= '0;
      end else begin
        case (state)
          ST_IDLE: if (tick) begin
            state <= ST_HIGH;
            tcnt  <= '0;
            beat  <= 1'b1;
          end
          ST_HIGH: if (tick) begin
            if (tcnt == HIGH_LAST) begin
              state <= ST_LOW;
              tcnt  <= '0;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          ST_LOW: if (tick) begin
            if (boundary) begin
              state <= ST_HIGH;
              tcnt  <= '0;
              beat  <= 1'b1;
            end else begin
              tcnt <= tcnt + 8'd1;
            end
          end
          default: begin
            state <= ST_IDLE;
            tcnt  <= '0;
          end
        endcase
      end
    end
  end

  assign pulse_out = (state == ST_HIGH);

endmodule

// File: tb/tb_pulse_gen.sv
// Directed bench for pulse_gen with TICK_DIV=4, HIGH_TICKS=10 (one tick = 4 cycles).
module tb_pulse_gen;

  typedef struct {
    logic [7:0] bpm;
    logic [7:0] exp_period;
  } vec_t;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       load;
  logic [7:0] bpm_set;
  logic       pulse_out;
  logic       beat;
  logic [7:0] period;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  pulse_gen #(.TICK_DIV(4), .HIGH_TICKS(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .enb       (enb),
    .load      (load),
    .bpm_set   (bpm_set),
    .pulse_out (pulse_out),
    .beat      (beat),
    .period    (period),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_beat(input string name, output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!beat && n < 2000);
    if (!beat) check({name, "_timeout"}, 0, 1);
    t = cyc;
  endtask

  task automatic do_load(input logic [7:0] v);
    load    = 1'b1;
    bpm_set = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic count_busy(output int n, output bit saw100);
    n = 0;
    saw100 = 0;
    while (busy && n < 40) begin
      n++;
      if (period == 8'd100) saw100 = 1;
      @(negedge clk);
    end
  endtask

  vec_t vecs[15];

  initial begin
    int t0, t1, t2, t3, tb_, w, n;
    bit saw100, bad;

    vecs[0]  = '{8'd7,   8'd200};
    vecs[1]  = '{8'd255, 8'd25};
    vecs[2]  = '{8'd29,  8'd200};
    vecs[3]  = '{8'd30,  8'd200};
    vecs[4]  = '{8'd31,  8'd193};
    vecs[5]  = '{8'd45,  8'd133};
    vecs[6]  = '{8'd60,  8'd100};
    vecs[7]  = '{8'd90,  8'd66};
    vecs[8]  = '{8'd100, 8'd60};
    vecs[9]  = '{8'd150, 8'd40};
    vecs[10] = '{8'd200, 8'd30};
    vecs[11] = '{8'd239, 8'd25};
    vecs[12] = '{8'd240, 8'd25};
    vecs[13] = '{8'd241, 8'd25};
    vecs[14] = '{8'd120, 8'd50};

    rst = 1'b1; enb = 1'b1; load = 1'b0; bpm_set = '0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_pulse_out", pulse_out, 0);
    check("reset_beat", beat, 0);
    check("reset_busy", busy, 0);
    check("reset_period", period, 100);

    // Default 60 bpm: first beat at first tick after synchronised release.
    rst = 1'b1;
    t0 = cyc;
    wait_beat("first_beat", t1);
    check("first_beat_latency", t1 - t0, 6);
    w = 1;
    @(negedge clk);
    while (pulse_out && w < 1000) begin
      w++;
      @(negedge clk);
    end
    check("pulse_width", w, 40);
    wait_beat("beat2", t2);
    check("beat_interval_100", t2 - t1, 400);

    // Load 90 bpm in LOW: current beat keeps 400 cycles, then 264.
    repeat (100) @(negedge clk);
    do_load(8'd90);
    wait_beat("beat3", t3);
    check("midlow_cur_beat", t3 - t2, 400);
    check("midlow_period", period, 66);
    wait_beat("beat4", t0);
    check("midlow_next_beat", t0 - t3, 264);

    // Drop enb in HIGH.
    repeat (10) @(negedge clk);
    enb = 1'b0;
    @(negedge clk);
    check("enb_drop_pulse", pulse_out, 0);
    repeat (50) @(negedge clk);
    check("enb_drop_idle", pulse_out, 0);

    // Clamp and divide table, applied in IDLE.
    foreach (vecs[i]) begin
      do_load(vecs[i].bpm);
      count_busy(n, saw100);
      check($sformatf("busy_len_bpm%0d", vecs[i].bpm), n, 13);
      @(negedge clk);
      check($sformatf("period_bpm%0d", vecs[i].bpm), period, vecs[i].exp_period);
    end

    // 120 bpm running.
    enb = 1'b1;
    wait_beat("run50_a", t0);
    wait_beat("run50_b", t1);
    check("beat_interval_50", t1 - t0, 200);

    // Load coincident with a beat boundary.
    while (cyc < t1 + 199) @(negedge clk);
    load = 1'b1;
    bpm_set = 8'd90;
    @(negedge clk);
    load = 1'b0;
    check("coincident_beat", beat, 1);
    tb_ = cyc;
    check("coincident_boundary_time", tb_ - t1, 200);
    wait_beat("coinc_next", t2);
    check("coincident_keeps_old", t2 - tb_, 200);
    check("coincident_period_applied", period, 66);
    wait_beat("coinc_after", t3);
    check("coincident_new_len", t3 - t2, 264);

    // Two loads 5 cycles apart.
    enb = 1'b0;
    repeat (3) @(negedge clk);
    bad = 0;
    do_load(8'd60);
    repeat (4) begin
      if (period == 8'd100) bad = 1;
      @(negedge clk);
    end
    do_load(8'd150);
    count_busy(n, saw100);
    check("double_load_busy", n, 13);
    @(negedge clk);
    check("double_load_period", period, 40);
    check("double_load_no_first", bad | saw100, 0);

    // Reset during a divide.
    do_load(8'd200);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_div_busy", busy, 0);
    check("rst_mid_div_period", period, 100);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || period != 8'd100) bad = 1;
    end
    check("rst_no_residual", bad, 0);
    check("rst_idle_pulse", pulse_out, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
